oflow_hist_buffer: RTL and testbench

Parametrised history-frame bounding-box buffer with integrated control FSM, sitting between the core FSM and the PE array. It stores each frame's bboxes into a circular set of frame slots, NUM_CH lanes per cycle. On request it streams back the bboxes of the last `num_of_history_frames` frames, newest first, with per-lane valid, stall support and per-slot occupancy tracking. It generalises the two-lane wrapper to N lanes, configurable depth and history, and variable-length frames.

---
 rtl/oflow_hist_buffer_pkg.sv | 34 +++
 rtl/oflow_hist_buffer_if.sv | 30 +++
 rtl/oflow_hist_bank.sv | 27 ++
 rtl/oflow_hist_buffer.sv | 190 +++++++++++++++++++
 tb/tb_oflow_hist_buffer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/oflow_hist_buffer_pkg.sv
// Shared types and widths for the history-frame bbox buffer.
//   - Width constants for the frame/history/bbox-count ports.
//   - Default geometry and the derived address widths for that geometry.
//   - FSM state enum.
//   - hist_depth(): how many history frames a read actually walks.
package oflow_hist_buffer_pkg;

  localparam int TOTAL_FRAME_NUM_WIDTH       = 8;
  localparam int NUM_OF_HISTORY_FRAMES_WIDTH = 3;
  localparam int NUM_OF_BBOX_IN_FRAME_WIDTH  = 6;

  localparam int DEF_MAX_BBOX = 32;
  localparam int DEF_MAX_HIST = 5;
  localparam int ADDR_W       = $clog2(DEF_MAX_BBOX);
  localparam int SLOT_W       = $clog2(DEF_MAX_HIST + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_SETUP,
    S_READ,
    S_RD_DRAIN
  } state_t;

  // A read can never reach further back than frame 0, nor past the slots held.
  function automatic int hist_depth(input int hist, input int max_hist, input int fn);
    int d;
    d = hist;
    if (d > max_hist) d = max_hist;
    if (d > fn) d = fn;
    return d;
  endfunction

endpackage

// File: rtl/oflow_hist_buffer_if.sv
// Write/read beat bus between the core/PE side and the history buffer.
//   wr_valid, wr_data       : write beat, lane i in wr_data[i*DATA_W +: DATA_W]
//   rd_stall                : PE back-pressure
//   rd_valid, rd_lane_valid : read beat / per-lane validity
//   rd_data, rd_age         : read beat payload and its age (1 = previous frame)
// master = core/PE side, slave = buffer.
interface oflow_hist_buffer_if
  import oflow_hist_buffer_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 64
);
  logic                                   wr_valid;
  logic [NUM_CH*DATA_W-1:0]               wr_data;
  logic                                   rd_stall;
  logic                                   rd_valid;
  logic [NUM_CH-1:0]                      rd_lane_valid;
  logic [NUM_CH*DATA_W-1:0]               rd_data;
  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] rd_age;

  modport master (
    output wr_valid, wr_data, rd_stall,
    input  rd_valid, rd_lane_valid, rd_data, rd_age
  );

  modport slave (
    input  wr_valid, wr_data, rd_stall,
    output rd_valid, rd_lane_valid, rd_data, rd_age
  );
endinterface

// File: rtl/oflow_hist_bank.sv
// One lane of bbox storage: 1R/1W synchronous RAM with registered read.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read port; rdata holds its value while re is low
//   rdata        : read data, one cycle after raddr
module oflow_hist_bank
  import oflow_hist_buffer_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 128,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/oflow_hist_buffer.sv
// History-frame bbox buffer: stores each frame's bboxes into slot
// (frame_num mod SLOTS), NUM_CH per beat, and streams back the last
// num_of_history_frames frames newest first.
//   clk, reset_N              : clock, async active-low reset
//   start_write / start_read  : start pulses, honoured only when idle (read wins)
//   frame_num                 : current frame serial number
//   num_of_history_frames     : requested history depth
//   num_of_bbox_in_frame      : bboxes in the frame being written
//   bus                       : write/read beat interface (slave side)
//   done_write / done_read    : one-cycle completion pulses
//   busy                      : FSM not idle
module oflow_hist_buffer
  import oflow_hist_buffer_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 64,
  parameter int MAX_BBOX = DEF_MAX_BBOX,
  parameter int MAX_HIST = DEF_MAX_HIST
) (
  input  logic                                   clk,
  input  logic                                   reset_N,
  input  logic                                   start_write,
  input  logic                                   start_read,
  input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
  input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
  input  logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  num_of_bbox_in_frame,
  oflow_hist_buffer_if.slave                     bus,
  output logic                                   done_write,
  output logic                                   done_read,
  output logic                                   busy
);
  localparam int SLOTS   = 2**$clog2(MAX_HIST + 1);
  localparam int SL_W    = $clog2(SLOTS);
  localparam int WORDS   = MAX_BBOX / NUM_CH;
  localparam int WORD_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LANE_SH = $clog2(NUM_CH);
  localparam int FW      = TOTAL_FRAME_NUM_WIDTH;
  localparam int HW      = NUM_OF_HISTORY_FRAMES_WIDTH;
  localparam int CW      = NUM_OF_BBOX_IN_FRAME_WIDTH;
  localparam int BW      = CW + 1;

  state_t          state, state_nxt;
  logic [FW-1:0]   fn_r;
  logic [HW-1:0]   hist_r;
  logic [CW-1:0]   nbbox_r;
  logic [BW-1:0]   base, base_nxt, base_step;
  logic [HW-1:0]   age, age_nxt, depth;
  logic [CW-1:0]   slot_count [SLOTS];
  logic [CW-1:0]   cur_cnt, sat_cnt;
  logic [FW-1:0]   rd_fn;
  logic [SL_W-1:0] rd_slot, wr_slot;
  logic [WORD_W-1:0] word;
  logic            start_take, commit, wr_fin, wr_last, frame_end;
  logic            done_write_nxt, done_read_nxt, vld_p0;
  logic [NUM_CH-1:0] lane_we, lane_hit, lane_vld_p0;
  logic [DATA_W-1:0] q_p1 [NUM_CH];

  assign depth     = HW'(hist_depth(int'(hist_r), MAX_HIST, int'(fn_r)));
  assign rd_fn     = fn_r - FW'(age);
  assign rd_slot   = rd_fn[SL_W-1:0];
  assign wr_slot   = fn_r[SL_W-1:0];
  assign cur_cnt   = slot_count[rd_slot];
  assign sat_cnt   = (int'(nbbox_r) > MAX_BBOX) ? CW'(MAX_BBOX) : nbbox_r;
  assign base_step = base + BW'(NUM_CH);
  assign word      = WORD_W'(base >> LANE_SH);
  assign wr_fin    = (base >= BW'(nbbox_r));
  assign wr_last   = (base_step >= BW'(nbbox_r));
  assign frame_end = (BW'(cur_cnt) <= base_step);
  assign start_take = (state == S_IDLE) && (start_read || start_write);
  assign busy      = (state != S_IDLE);

  always_comb begin
    lane_we  = '0;
    lane_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Lanes past the frame end or past MAX_BBOX are dropped, not wrapped.
      lane_we[i]  = (state == S_WRITE) && !wr_fin && bus.wr_valid &&
                    ((base + BW'(i)) < BW'(nbbox_r)) &&
                    (int'(base + BW'(i)) < MAX_BBOX);
      lane_hit[i] = (base + BW'(i)) < BW'(cur_cnt);
    end
  end

  always_comb begin
    state_nxt      = state;
    base_nxt       = base;
    age_nxt        = age;
    done_write_nxt = 1'b0;
    done_read_nxt  = 1'b0;
    commit         = 1'b0;
    vld_p0         = 1'b0;
    lane_vld_p0    = '0;
    case (state)
      S_IDLE: begin
        base_nxt = '0;
        age_nxt  = HW'(1);
        if (start_read)       state_nxt = S_RD_SETUP;
        else if (start_write) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (wr_fin || (bus.wr_valid && wr_last)) begin
          commit         = 1'b1;
          done_write_nxt = 1'b1;
          state_nxt      = S_IDLE;
        end else if (bus.wr_valid) begin
          base_nxt = base_step;
        end
      end
      S_RD_SETUP, S_READ: begin
        // RD_SETUP already issues the first address so data lands two
        // cycles after start_read. Zero-count frames consume a cycle but no beat.
        if (state == S_RD_SETUP && depth == '0) begin
          done_read_nxt = 1'b1;
          state_nxt     = S_IDLE;
        end else if (!bus.rd_stall) begin
          state_nxt   = S_READ;
          vld_p0      = (cur_cnt != '0);
          lane_vld_p0 = vld_p0 ? lane_hit : '0;
          if (frame_end) begin
            base_nxt = '0;
            if (age >= depth) state_nxt = S_RD_DRAIN;
            else              age_nxt   = age + HW'(1);
          end else begin
            base_nxt = base_step;
          end
        end
      end
      S_RD_DRAIN: begin
        if (!bus.rd_stall) begin
          done_read_nxt = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state             <= S_IDLE;
      fn_r              <= '0;
      hist_r            <= '0;
      nbbox_r           <= '0;
      base              <= '0;
      age               <= '0;
      done_write        <= 1'b0;
      done_read         <= 1'b0;
      bus.rd_valid      <= 1'b0;
      bus.rd_lane_valid <= '0;
      bus.rd_age        <= '0;
      for (int s = 0; s < SLOTS; s++) slot_count[s] <= '0;
    end else begin
      state      <= state_nxt;
      base       <= base_nxt;
      age        <= age_nxt;
      done_write <= done_write_nxt;
      done_read  <= done_read_nxt;
      if (start_take) begin
        fn_r    <= frame_num;
        hist_r  <= num_of_history_frames;
        nbbox_r <= num_of_bbox_in_frame;
      end
      if (commit) slot_count[wr_slot] <= sat_cnt;
      // p0 -> p1: beat qualifiers follow the RAM read, frozen under stall
      if (!bus.rd_stall) begin
        bus.rd_valid      <= vld_p0;
        bus.rd_lane_valid <= lane_vld_p0;
        bus.rd_age        <= vld_p0 ? age : '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    oflow_hist_bank #(
      .DATA_W(DATA_W),
      .DEPTH (SLOTS * WORDS),
      .AW    (SL_W + WORD_W)
    ) u_bank (
      .clk  (clk),
      .we   (lane_we[g]),
      .waddr({wr_slot, word}),
      .wdata(bus.wr_data[g*DATA_W +: DATA_W]),
      .re   (!bus.rd_stall),
      .raddr({rd_slot, word}),
      .rdata(q_p1[g])
    );
    // Masked lanes and idle cycles read as zero, including straight after reset.
    assign bus.rd_data[g*DATA_W +: DATA_W] = bus.rd_lane_valid[g] ? q_p1[g] : '0;
  end
endmodule

// File: tb/tb_oflow_hist_buffer.sv
// Scoreboard bench for oflow_hist_buffer (NUM_CH=2, MAX_BBOX=32, MAX_HIST=5).
module tb_oflow_hist_buffer;
  import oflow_hist_buffer_pkg::*;

  localparam int NUM_CH   = 2;
  localparam int DATA_W   = 64;
  localparam int MAX_BBOX = 32;
  localparam int MAX_HIST = 5;
  localparam int SLOTS    = 8;
  localparam int W        = NUM_CH * DATA_W;

  typedef struct packed {
    logic [NUM_CH-1:0] lv;
    logic [W-1:0]      data;
    logic [2:0]        age;
  } beat_t;

  logic clk = 1'b0;
  logic reset_N, start_write, start_read, done_write, done_read, busy;
  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num;
  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames;
  logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  num_of_bbox_in_frame;

  oflow_hist_buffer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  oflow_hist_buffer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_BBOX(MAX_BBOX), .MAX_HIST(MAX_HIST)
  ) dut (
    .clk                  (clk),
    .reset_N              (reset_N),
    .start_write          (start_write),
    .start_read           (start_read),
    .frame_num            (frame_num),
    .num_of_history_frames(num_of_history_frames),
    .num_of_bbox_in_frame (num_of_bbox_in_frame),
    .bus                  (bus),
    .done_write           (done_write),
    .done_read            (done_read),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;
  beat_t exp_q[$];
  int beats_seen = 0;
  int first_vld = -1;
  int last_vld = -1;
  int dw_seen = 0;
  int mcount[SLOTS];
  int mframe[SLOTS];

  function automatic logic [63:0] val(input int f, input int k);
    return {8'hA5, 24'(f), 32'(k) ^ 32'h5A5A_0000};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_data(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: peek while stalled (output must stay on the same beat), pop when taken.
  always @(negedge clk) begin
    if (done_write) dw_seen++;
    if (reset_N && bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got lanes=%b age=%0d expected no beat", bus.rd_lane_valid, bus.rd_age);
      end else begin
        chk("rd_lane_valid", int'(bus.rd_lane_valid), int'(exp_q[0].lv));
        chk_data("rd_data", bus.rd_data, exp_q[0].data);
        chk("rd_age", int'(bus.rd_age), int'(exp_q[0].age));
        if (first_vld < 0) first_vld = cyc;
        if (!bus.rd_stall) begin
          void'(exp_q.pop_front());
          beats_seen++;
          last_vld = cyc;
        end
      end
    end
  end

  task automatic write_frame(input int f, input int n);
    int beats;
    beats = (n + NUM_CH - 1) / NUM_CH;
    @(posedge clk); #1;
    frame_num            = 8'(f);
    num_of_bbox_in_frame = 6'(n);
    start_write          = 1'b1;
    @(posedge clk); #1;
    start_write = 1'b0;
    for (int b = 0; b < beats; b++) begin
      bus.wr_valid = 1'b1;
      for (int i = 0; i < NUM_CH; i++) bus.wr_data[i*DATA_W +: DATA_W] = val(f, b*NUM_CH + i);
      @(posedge clk); #1;
    end
    bus.wr_valid = 1'b0;
    if (beats == 0) begin
      @(posedge clk); #1;
    end
    chk("done_write", int'(done_write), 1);
    mcount[f % SLOTS] = (n > MAX_BBOX) ? MAX_BBOX : n;
    mframe[f % SLOTS] = f;
    @(posedge clk); #1;
    chk("busy_after_write", int'(busy), 0);
  endtask

  // exp_beats is hand-computed by the caller; exp_lat >= 0 checks start->done_read.
  task automatic read_hist(input int f, input int hist, input int exp_beats,
                           input int exp_lat, input bit also_write);
    int depth, t0, tdone, dw0, s, c;
    beat_t e;
    depth = hist;
    if (depth > MAX_HIST) depth = MAX_HIST;
    if (depth > f) depth = f;
    for (int a = 1; a <= depth; a++) begin
      s = (f - a) % SLOTS;
      c = mcount[s];
      for (int b = 0; b < c; b += NUM_CH) begin
        e.lv   = '0;
        e.data = '0;
        e.age  = 3'(a);
        for (int i = 0; i < NUM_CH; i++) begin
          if (b + i < c) begin
            e.lv[i] = 1'b1;
            e.data[i*DATA_W +: DATA_W] = val(mframe[s], b + i);
          end
        end
        exp_q.push_back(e);
      end
    end
    beats_seen = 0;
    first_vld  = -1;
    last_vld   = -1;
    dw0        = dw_seen;
    @(posedge clk); #1;
    frame_num             = 8'(f);
    num_of_history_frames = 3'(hist);
    start_read            = 1'b1;
    start_write           = also_write;
    t0 = cyc;
    @(posedge clk); #1;
    start_read  = 1'b0;
    start_write = 1'b0;
    tdone = -1;
    for (int k = 0; k < 400 && tdone < 0; k++) begin
      @(negedge clk);
      if (done_read) tdone = cyc;
    end
    if (tdone < 0) begin
      total++;
      bad++;
      $display("FAIL done_read_timeout: got no done_read expected one within 400 cycles");
    end
    chk("beat_count", beats_seen, exp_beats);
    chk("queue_left", exp_q.size(), 0);
    exp_q.delete();
    if (exp_beats > 0) begin
      chk("first_beat_latency", first_vld - t0, 2);
      chk("done_after_last_beat", tdone - last_vld, 1);
    end
    if (exp_lat >= 0) chk("done_read_latency", tdone - t0, exp_lat);
    @(posedge clk); #1;
    chk("busy_after_read", int'(busy), 0);
    chk("no_write_during_read", dw_seen - dw0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int dw0;
    reset_N = 1'b0;
    start_write = 1'b0;
    start_read = 1'b0;
    frame_num = '0;
    num_of_history_frames = '0;
    num_of_bbox_in_frame = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.rd_stall = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      mcount[s] = 0;
      mframe[s] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_rd_valid", int'(bus.rd_valid), 0);
    chk("reset_done_write", int'(done_write), 0);
    chk("reset_done_read", int'(done_read), 0);
    chk("reset_rd_lane_valid", int'(bus.rd_lane_valid), 0);
    chk_data("reset_rd_data", bus.rd_data, '0);
    reset_N = 1'b1;

    // Frame 0, 5 bboxes: 3 beats, last beat lanes 2'b01, age 1.
    write_frame(0, 5);
    read_hist(1, 3, 3, -1, 1'b0);

    // frame_num=0: nothing to read; simultaneous start_write is ignored.
    read_hist(0, 3, 0, 2, 1'b1);

    // Frames 0..7 with counts 1..8; ages 1..5 give 4+4+3+3+2 beats.
    for (int f = 0; f < 8; f++) write_frame(f, f + 1);
    read_hist(8, 5, 16, -1, 1'b0);

    // Frame 8: 3, frame 9: empty, frame 10: 40 (saturates at 32).
    // hist=7 clamps to 5: 16 + 0 + 2 + 4 + 4 beats, with a 3-cycle stall mid-read.
    write_frame(8, 3);
    write_frame(9, 0);
    write_frame(10, 40);
    fork
      read_hist(11, 7, 26, -1, 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1 bus.rd_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.rd_stall = 1'b0;
      end
    join

    // Reset in the middle of a write.
    @(posedge clk); #1;
    frame_num = 8'd12;
    num_of_bbox_in_frame = 6'd6;
    start_write = 1'b1;
    @(posedge clk); #1;
    start_write = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data = {val(12, 1), val(12, 0)};
    dw0 = dw_seen;
    @(posedge clk); #3;
    reset_N = 1'b0;
    #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done_write", int'(done_write), 0);
    chk("midreset_rd_valid", int'(bus.rd_valid), 0);
    chk("midreset_rd_age", int'(bus.rd_age), 0);
    bus.wr_valid = 1'b0;
    for (int s = 0; s < SLOTS; s++) mcount[s] = 0;
    repeat (2) @(posedge clk);
    #1 reset_N = 1'b1;
    chk("midreset_no_done", dw_seen - dw0, 0);
    read_hist(12, 5, 0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
